// File: rtl/fsm_counter_pkg.sv
// Shared definitions for the run-length counter scheduler: state encoding
// and default sizing. Arbitration policy is selected by the
// FSM_COUNTER_SCHED_RR_EN macro (see sched_pick / fsm_counter_sched).
package fsm_counter_pkg;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sched_pick.sv
// Combinational winner selection for the scheduler, one-hot output.
// FSM_COUNTER_SCHED_RR_EN defined: round-robin, search starts just above
// the last granted index (ptr) and wraps. Undefined: lowest index wins.
module sched_pick
    import fsm_counter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
`ifdef FSM_COUNTER_SCHED_RR_EN
    input  logic [PW-1:0]   ptr,
`endif
    output logic [NREQ-1:0] win
);

`ifdef FSM_COUNTER_SCHED_RR_EN
    logic [NREQ-1:0] above;
    logic [NREQ-1:0] hi;

    // Prefer the lowest requester strictly above ptr; otherwise wrap to the lowest overall.
    always_comb begin
        above = ~((NREQ'(2) << ptr) - NREQ'(1));
        hi    = req & above;
        if (hi != '0) begin
            win = hi & (~hi + NREQ'(1));
        end else begin
            win = req & (~req + NREQ'(1));
        end
    end
`else
    // Isolate the lowest set request bit.
    always_comb begin
        win = req & (~req + NREQ'(1));
    end
`endif

endmodule

// File: rtl/fsm_counter_sched.sv
// Scheduler sharing one run-length counter between NREQ requesters:
// arbitrate in IDLE, latch the winner's length, count the run, pulse done.
// FSM_COUNTER_SCHED_RR_EN selects round-robin arbitration (default: fixed
// priority, lowest index wins, no pointer register).
module fsm_counter_sched
    import fsm_counter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [CW-1:0]     cnt,
    output logic              out
);

    localparam int PW = $clog2(NREQ);

    state_t          state;
    logic [CW-1:0]   len_q;
    logic [NREQ-1:0] pick;
    logic [CW-1:0]   len_acc [NREQ+1];
    logic [CW-1:0]   len_sel;

`ifdef FSM_COUNTER_SCHED_RR_EN
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   idx_acc [NREQ+1];
    logic [PW-1:0]   gnt_idx;

    sched_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick)
    );
`else
    sched_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (req),
        .win (pick)
    );
`endif

    // One-hot mux of the winner's length slice.
    assign len_acc[0] = '0;
    for (genvar g = 0; g < NREQ; g++) begin : g_len
        assign len_acc[g+1] = len_acc[g] | (pick[g] ? len[g*CW +: CW] : '0);
    end
    assign len_sel = len_acc[NREQ];

`ifdef FSM_COUNTER_SCHED_RR_EN
    // Encode the registered one-hot grant back to an index for the pointer.
    assign idx_acc[0] = '0;
    for (genvar g = 0; g < NREQ; g++) begin : g_idx
        assign idx_acc[g+1] = idx_acc[g] | (gnt[g] ? PW'(g) : '0);
    end
    assign gnt_idx = idx_acc[NREQ];

    // Pointer remembers the last granted requester; it moves while in LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= PW'(NREQ - 1);
        end else if (state == LOAD) begin
            ptr <= gnt_idx;
        end
    end
`endif

    // Control FSM with registered grant, done/out pulses, busy and counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            out   <= 1'b0;
            len_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        gnt   <= pick;
                        len_q <= len_sel;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                    if (len_q == '0) begin
                        done  <= gnt;
                        out   <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // len_q is nonzero here, so len_q-1 cannot underflow and cnt never wraps.
                    if (cnt == len_q - CW'(1)) begin
                        cnt   <= '0;
                        done  <= gnt;
                        out   <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= '0;
                    out   <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_counter_sched.sv
// Self-checking bench for fsm_counter_sched: a cycle-position model checked
// every cycle, plus directed tests with hand-computed expectations.
// Honours FSM_COUNTER_SCHED_RR_EN for the expected arbitration order.
module tb_fsm_counter_sched;

    localparam int NREQ = 4;
    localparam int CW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [CW-1:0]     cnt;
    logic              out;

    int n_chk  = 0;
    int n_fail = 0;

    fsm_counter_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .len  (len),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .cnt  (cnt),
        .out  (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bit seen;
        seen = 1'b0;
        req  = '0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step(1);
            if (!busy) seen = 1'b1;
        end
        chk("idle_wait_busy", 32'(busy), 32'd0);
    endtask

    // Winner chosen by the arbitration rule, given the last granted index.
    function automatic int pick_model(input logic [NREQ-1:0] r, input int last);
`ifdef FSM_COUNTER_SCHED_RR_EN
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++)
            if (r[i]) return i;
        if (last < 0) return 0;
`endif
        return 0;
    endfunction

    // Model: m_pos counts cycles since the IDLE sampling cycle (0 = idle).
    // Positions 1..len+2 are LOAD, RUN x len, DONE; the next cycle is IDLE.
    int              m_pos  = 0;
    int              m_len  = 0;
    int              m_win  = 0;
    int              m_last = NREQ - 1;
    logic [NREQ-1:0] e_gnt, e_done;
    logic [CW-1:0]   e_cnt;
    logic            e_busy, e_out;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_pos  = 0;
                m_last = NREQ - 1;
            end
            e_gnt  = '0;
            e_done = '0;
            e_cnt  = '0;
            e_busy = 1'b0;
            e_out  = 1'b0;
            if (m_pos != 0) begin
                e_gnt  = NREQ'(1) << m_win;
                e_busy = 1'b1;
                if (m_pos >= 2 && m_pos <= m_len + 1) e_cnt = CW'(m_pos - 2);
                if (m_pos == m_len + 2) begin
                    e_done = e_gnt;
                    e_out  = 1'b1;
                end
            end
            chk("mon_gnt",  32'(gnt),  32'(e_gnt));
            chk("mon_done", 32'(done), 32'(e_done));
            chk("mon_busy", 32'(busy), 32'(e_busy));
            chk("mon_cnt",  32'(cnt),  32'(e_cnt));
            chk("mon_out",  32'(out),  32'(e_out));
            if (rst) begin
                if (m_pos == 0) begin
                    if (req != '0) begin
                        m_win  = pick_model(req, m_last);
                        m_len  = int'(len[m_win*CW +: CW]);
                        m_last = m_win;
                        m_pos  = 1;
                    end
                end else if (m_pos == m_len + 2) begin
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] exp_g;
        rst = 1'b0;
        req = '0;
        len = '0;

        // Reset state
        step(2);
        chk("rst_gnt",  32'(gnt),  32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt",  32'(cnt),  32'd0);
        chk("rst_out",  32'(out),  32'd0);
        rst = 1'b1;
        step(1);

        // Contention: all requesting, len=2 each; first grant right after reset
        for (int i = 0; i < NREQ; i++) len[i*CW +: CW] = 8'd2;
        req = '1;
        step(1);
        chk("cont_gnt0", 32'(gnt), 32'h1);
        for (int g = 1; g < 5; g++) begin
`ifdef FSM_COUNTER_SCHED_RR_EN
            exp_g = NREQ'(1) << (g % NREQ);
`else
            exp_g = NREQ'(1);
`endif
            step(4);
            chk("cont_idle_gap", 32'(gnt), 32'd0);
            step(1);
            chk("cont_gnt", 32'(gnt), 32'(exp_g));
        end
        go_idle();

        // Single request, len0=5
        len[0 +: CW] = 8'd5;
        req = 4'b0001;
        step(1);
        chk("single_gnt_c1", 32'(gnt), 32'h1);
        req = '0;
        step(1);
        chk("single_cnt_c2", 32'(cnt), 32'd0);
        step(4);
        chk("single_cnt_c6", 32'(cnt), 32'd4);
        step(1);
        chk("single_done_c7", 32'(done), 32'h1);
        chk("single_out_c7",  32'(out),  32'd1);
        step(1);
        chk("single_busy_c8", 32'(busy), 32'd0);
        go_idle();

        // Zero length on requester 2
        len[2*CW +: CW] = 8'd0;
        req = 4'b0100;
        step(1);
        chk("zero_gnt", 32'(gnt), 32'h4);
        req = '0;
        step(1);
        chk("zero_done", 32'(done), 32'h4);
        chk("zero_cnt",  32'(cnt),  32'd0);
        step(1);
        chk("zero_busy_after", 32'(busy), 32'd0);
        go_idle();

        // Request dropped and length changed mid-run, len0=6
        len[0 +: CW] = 8'd6;
        req = 4'b0001;
        step(1);
        chk("drop_gnt", 32'(gnt), 32'h1);
        step(1);
        req = '0;
        len[0 +: CW] = 8'd1;
        step(5);
        chk("drop_cnt_c7", 32'(cnt), 32'd5);
        step(1);
        chk("drop_done_c8", 32'(done), 32'h1);
        go_idle();

        // Reset mid-run at cnt=3, then a fresh grant to requester 1
        len[0 +: CW] = 8'd10;
        req = 4'b0001;
        step(1);
        req = '0;
        step(4);
        chk("rmid_cnt3", 32'(cnt), 32'd3);
        rst = 1'b0;
        #1;
        chk("rmid_gnt",  32'(gnt),  32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_cnt",  32'(cnt),  32'd0);
        chk("rmid_done", 32'(done), 32'd0);
        chk("rmid_out",  32'(out),  32'd0);
        step(3);
        rst = 1'b1;
        step(1);
        len[1*CW +: CW] = 8'd1;
        req = 4'b0010;
        step(1);
        chk("rmid_regnt", 32'(gnt), 32'h2);
        req = '0;
        step(2);
        chk("rmid_redone", 32'(done), 32'h2);
        go_idle();

        // Maximum length 255
        len[0 +: CW] = 8'd255;
        req = 4'b0001;
        step(1);
        chk("max_gnt", 32'(gnt), 32'h1);
        req = '0;
        step(255);
        chk("max_cnt_c256", 32'(cnt), 32'd254);
        step(1);
        chk("max_done_c257", 32'(done), 32'h1);
        chk("max_out_c257",  32'(out),  32'd1);
        chk("max_cnt_c257",  32'(cnt),  32'd0);
        step(1);
        chk("max_busy_c258", 32'(busy), 32'd0);
        go_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_counter_sched.md
# fsm_counter_sched

Scheduler that shares one run-length counter between `NREQ` requesters. It arbitrates pending requests, latches the winner's run length, sequences the count run, and returns a per-requester completion pulse. It sits in front of the counter datapath of the `03_fsm` designs and gives every client a single start/done handshake.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `CW`, default 8: counter and length width.

- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-low reset.
- `req`  in  NREQ: per-requester run request, level.
- `len`  in  NREQ*CW: run length; slice `[i*CW +: CW]` belongs to requester i.
- `gnt`  out  NREQ: one-hot grant, registered.
- `done`  out  NREQ: one-cycle completion pulse to the granted requester.
- `busy`  out  1: high in every state except IDLE.
- `cnt`  out  CW: current count.
- `out`  out  1: one-cycle terminal-count pulse, same cycle as `done`.

## Operation
- State machine has four states: IDLE, LOAD, RUN, DONE.
- **IDLE**:
  - If any `req` bit is high, pick a winner, register `gnt`, latch the winner's `len` into `len_q`, then go to LOAD.
  - If no `req` bit is high, stay in IDLE.
- **LOAD**: clear `cnt`. Go to DONE if `len_q`==0, else go to RUN.
- **RUN**: `cnt` increments by 1 each cycle. When `cnt`==`len_q`-1, go to DONE.
- **DONE**: assert `done[winner]` and `out` for one cycle, then go to IDLE.
- `gnt` is high from LOAD through DONE inclusive and low in IDLE.
- `cnt` reads 0 in IDLE, LOAD and DONE. In RUN it reads 0..`len_q`-1.
- Arithmetic is unsigned CW-bit. `len`=2^CW-1 is the maximum run and `cnt` never wraps.
- `req` and `len` are sampled only in IDLE.
  - Dropping `req` mid-run does not abort the run; `done` still pulses.
  - Changing `len` mid-run has no effect.
- A requester that keeps `req` high after its `done` re-competes in the next IDLE cycle.

## Timing
- A request sampled in IDLE at cycle 0 gives this sequence:
  - LOAD at cycle 1, `gnt` visible.
  - RUN for cycles 2..`len`+1.
  - DONE at cycle `len`+2.
  - IDLE at cycle `len`+3.
- Grant-to-done takes `len`+2 cycles; a zero-length run takes 2 cycles (LOAD, DONE).
- With back-to-back requests there is exactly one IDLE cycle between grants.
- Reset values while `rst`=0: state IDLE, `gnt`=0, `done`=0, `busy`=0, `cnt`=0, `out`=0, `len_q`=0, priority pointer `NREQ`-1.
- Reset asserted mid-run clears all of the above immediately. No `done` is issued for the aborted run.
- Simultaneous requests are resolved in the same IDLE cycle with no extra latency.

## Configuration
- `FSM_COUNTER_SCHED_RR_EN` defined: round-robin arbitration.
  - The pointer holds the last granted index and the search starts at pointer+1, modulo `NREQ`.
  - The pointer updates in LOAD.
  - After reset, requester 0 wins first.
- `FSM_COUNTER_SCHED_RR_EN` undefined: fixed priority, lowest index wins. The pointer logic is absent.

## Structure
- Shared package `fsm_counter_pkg` holds:
  - the state encoding constants (IDLE=0, LOAD=1, RUN=2, DONE=3, 2 bits);
  - default `NREQ`/`CW` constants.
- One sub-module, `sched_pick`:
  - combinational winner selection from `req` and pointer, producing a one-hot output;
  - the macro-controlled arbitration policy lives here.
- The top level holds the FSM, `len_q`, `cnt` and the output registers.

## Test plan
- **Single request**: `req`=0001, `len0`=5.
  - `gnt`=0001 at cycle 1.
  - `cnt` 0..4 in cycles 2..6.
  - `done[0]` and `out` high at cycle 7.
  - IDLE at cycle 8.
- **Zero length**: `req`=0100, `len2`=0. LOAD then DONE; `done[2]` 2 cycles after the grant; `cnt` stays 0.
- **Contention, RR**: `req`=1111 held, all `len`=2. Grants go 0,1,2,3,0 with one IDLE cycle between them. Without the macro, requester 0 is granted every time.
- **Request dropped mid-run**: `req0` deasserted in RUN with `len0`=6. The run completes and `done[0]` still pulses at cycle 8.
- **Reset mid-run**: `rst`=0 at RUN with `cnt`=3.
  - All outputs go to 0 asynchronously and no `done` pulses.
  - After release, `req`=0010 is granted normally with `gnt`=0010.
- **Max length**: `len`=255 with CW=8. `cnt` reaches 254 without wrapping and `done` pulses at cycle 257.
